// File: rtl/gray_count_checker_if.sv
// Bus between the gray counter side and the gray counter checker.
// The master drives the sampled code and controls; the slave returns status.
interface gray_count_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     gray_in;
    logic                 sample_en;
    logic                 clr_err;
    logic [WIDTH-1:0]     bin_out;
    logic                 locked;
    logic                 step_err;
    logic                 wrap_pulse;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output gray_in, sample_en, clr_err,
        input  bin_out, locked, step_err, wrap_pulse, err_count
    );

    modport slave (
        input  gray_in, sample_en, clr_err,
        output bin_out, locked, step_err, wrap_pulse, err_count
    );
endinterface

// File: rtl/gray_count_checker.sv
// Gray counter monitor.
// Samples a gray code, converts it to binary and checks that each new sample
// is the previous one plus one. After LOCK_LEN good steps it locks, then flags
// bad steps, counts them with saturation and pulses on wrap-around.
module gray_count_checker #(
    parameter int WIDTH     = 4,
    parameter int LOCK_LEN  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    gray_count_checker_if.slave bus
);
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [3:0] LOCK_CNT = LOCK_LEN[3:0];

    logic [1:0]           r_state;
    logic [3:0]           r_good_cnt;
    logic [WIDTH-1:0]     r_bin;
    logic                 r_step_err;
    logic                 r_wrap;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic [WIDTH-1:0]     w_new;
    logic [WIDTH-1:0]     w_prev_inc;
    logic [3:0]           w_cnt_inc;
    logic                 w_good;
    logic                 w_stall;
    logic                 w_wrap;
    logic [1:0]           w_state_nxt;
    logic [3:0]           w_cnt_nxt;
    logic [WIDTH-1:0]     w_bin_nxt;
    logic                 w_step_nxt;
    logic                 w_wrap_nxt;
    logic                 w_err_inc;
    logic [ERR_CNT_W-1:0] w_err_nxt;

    // Gray-to-binary conversion, MSB first: each bit folds in the one above it.
    always_comb begin
        w_new = '0;
        w_new[WIDTH-1] = bus.gray_in[WIDTH-1];
        for (int unsigned k = 1; k < WIDTH; k++) begin
            w_new[WIDTH-1-k] = w_new[WIDTH-k] ^ bus.gray_in[WIDTH-1-k];
        end
    end

    assign w_prev_inc = r_bin + 1'b1;
    assign w_cnt_inc  = r_good_cnt + 4'd1;
    assign w_good     = (w_new == w_prev_inc);
    assign w_stall    = (w_new == r_bin);
    assign w_wrap     = w_good && (r_bin == '1);

    // Step classification and lock FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_good_cnt;
        w_bin_nxt   = r_bin;
        w_step_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_err_inc   = 1'b0;
        if (bus.sample_en) begin
            w_bin_nxt = w_new;
            case (r_state)
                ST_EMPTY: begin
                    w_state_nxt = ST_ACQUIRE;
                    w_cnt_nxt   = 4'd0;
                end
                ST_ACQUIRE: begin
                    if (w_good) begin
                        w_wrap_nxt = w_wrap;
                        if (w_cnt_inc == LOCK_CNT) begin
                            w_state_nxt = ST_LOCKED;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else if (!w_stall) begin
                        w_cnt_nxt = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (w_good) begin
                        w_wrap_nxt = w_wrap;
                    end else if (!w_stall) begin
                        w_step_nxt  = 1'b1;
                        w_err_inc   = 1'b1;
                        w_state_nxt = ST_ACQUIRE;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Saturating error counter; a clear wins over a same-edge increment.
    always_comb begin
        w_err_nxt = r_err_cnt;
        if (bus.clr_err) begin
            w_err_nxt = '0;
        end else if (w_err_inc && (r_err_cnt != '1)) begin
            w_err_nxt = r_err_cnt + 1'b1;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_good_cnt <= 4'd0;
            r_bin      <= '0;
            r_step_err <= 1'b0;
            r_wrap     <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_cnt_nxt;
            r_bin      <= w_bin_nxt;
            r_step_err <= w_step_nxt;
            r_wrap     <= w_wrap_nxt;
            r_err_cnt  <= w_err_nxt;
        end
    end

    assign bus.bin_out    = r_bin;
    assign bus.locked     = (r_state == ST_LOCKED);
    assign bus.step_err   = r_step_err;
    assign bus.wrap_pulse = r_wrap;
    assign bus.err_count  = r_err_cnt;
endmodule

// File: tb/tb_gray_count_checker.sv
// Scoreboard bench for gray_count_checker (WIDTH=4, LOCK_LEN=2, ERR_CNT_W=2).
module tb_gray_count_checker;
    localparam int W  = 4;
    localparam int LL = 2;
    localparam int EW = 2;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    gray_count_checker_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus ();

    gray_count_checker #(.WIDTH(W), .LOCK_LEN(LL), .ERR_CNT_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  bin;
        logic          lk;
        logic          se;
        logic          wp;
        logic [EW-1:0] ec;
    } exp_t;

    exp_t q[$];

    // reference model state
    int m_state;   // 0 empty, 1 acquire, 2 locked
    int m_cnt;
    int m_bin;
    int m_err;
    int m_se;
    int m_wp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_gray(input int b);
        logic [W-1:0] v;
        v = b[W-1:0];
        return v ^ (v >> 1);
    endfunction

    function automatic int from_gray(input logic [W-1:0] g);
        int r;
        r = 0;
        for (int i = 0; i < W; i++) r[i] = ^(g >> i);
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_bin = 0; m_err = 0; m_se = 0; m_wp = 0;
    endtask

    task automatic model_step(input logic [W-1:0] g, input logic en, input logic clr);
        int nv;
        bit good, stall, inc;
        m_se = 0; m_wp = 0; inc = 0;
        if (en) begin
            nv    = from_gray(g);
            good  = (nv == ((m_bin + 1) % (1 << W)));
            stall = (nv == m_bin);
            if (m_state == 0) begin
                m_state = 1; m_cnt = 0;
            end else begin
                if (good && m_bin == (1 << W) - 1) m_wp = 1;
                if (m_state == 1) begin
                    if (good) begin
                        m_cnt++;
                        if (m_cnt == LL) begin m_state = 2; m_cnt = 0; end
                    end else if (!stall) m_cnt = 0;
                end else begin
                    if (!good && !stall) begin
                        m_se = 1; inc = 1; m_state = 1; m_cnt = 0;
                    end
                end
            end
            m_bin = nv;
        end
        if (clr) m_err = 0;
        else if (inc && m_err < (1 << EW) - 1) m_err++;
    endtask

    // Drive one cycle, push the model's expectation, then pop and compare after the edge.
    task automatic step(input logic [W-1:0] g, input logic en, input logic clr, input string tag);
        exp_t e;
        @(negedge clk);
        bus.gray_in   = g;
        bus.sample_en = en;
        bus.clr_err   = clr;
        model_step(g, en, clr);
        e.bin = m_bin[W-1:0]; e.lk = (m_state == 2); e.se = m_se[0]; e.wp = m_wp[0]; e.ec = m_err[EW-1:0];
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk({tag, "_bin"},  32'(bus.bin_out),    32'(e.bin));
            chk({tag, "_lock"}, 32'(bus.locked),     32'(e.lk));
            chk({tag, "_serr"}, 32'(bus.step_err),   32'(e.se));
            chk({tag, "_wrap"}, 32'(bus.wrap_pulse), 32'(e.wp));
            chk({tag, "_ecnt"}, 32'(bus.err_count),  32'(e.ec));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bin"},  32'(bus.bin_out),    32'd0);
        chk({tag, "_lock"}, 32'(bus.locked),     32'd0);
        chk({tag, "_serr"}, 32'(bus.step_err),   32'd0);
        chk({tag, "_wrap"}, 32'(bus.wrap_pulse), 32'd0);
        chk({tag, "_ecnt"}, 32'(bus.err_count),  32'd0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        model_reset();
        rst = 1'b1;
        bus.gray_in = '0; bus.sample_en = 1'b0; bus.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: lock on 0,1,2,3
        for (int b = 0; b < 4; b++) step(to_gray(b), 1'b1, 1'b0, "lock");
        chk("lock_final", 32'(bus.locked), 32'd1);

        // 2: run up to 15 then wrap to 0
        for (int b = 4; b < 16; b++) step(to_gray(b), 1'b1, 1'b0, "run");
        step(to_gray(0), 1'b1, 1'b0, "wrap");
        chk("wrap_pulse", 32'(bus.wrap_pulse), 32'd1);
        step(to_gray(1), 1'b1, 1'b0, "postwrap");
        chk("postwrap_pulse", 32'(bus.wrap_pulse), 32'd0);

        // 3: counter reset while locked at 5
        for (int b = 2; b < 6; b++) step(to_gray(b), 1'b1, 1'b0, "to5");
        step(4'b0000, 1'b1, 1'b0, "jump0");
        chk("jump0_err", 32'(bus.err_count), 32'd1);
        step(4'b0001, 1'b1, 1'b0, "relock");
        step(4'b0011, 1'b1, 1'b0, "relock");
        chk("relock_lk", 32'(bus.locked), 32'd1);

        // 4: stalls then sample_en gaps
        step(4'b0010, 1'b1, 1'b0, "pre4");
        repeat (3) step(4'b0110, 1'b1, 1'b0, "stall");
        for (int i = 0; i < 4; i++) step(W'($urandom_range(0, 15)), 1'b0, 1'b0, "gap");
        chk("gap_bin", 32'(bus.bin_out), 32'd4);

        // 5: clear, then 5 bad steps with relock in between -> saturates at 3
        step(to_gray(5), 1'b1, 1'b1, "clr");
        for (int k = 0; k < 5; k++) begin
            step(to_gray((m_bin + 7) % 16), 1'b1, 1'b0, "bad");
            step(to_gray((m_bin + 1) % 16), 1'b1, 1'b0, "rl");
            step(to_gray((m_bin + 1) % 16), 1'b1, 1'b0, "rl");
        end
        chk("sat", 32'(bus.err_count), 32'd3);
        step(to_gray((m_bin + 9) % 16), 1'b1, 1'b1, "clrbad");
        chk("clrbad_cnt", 32'(bus.err_count), 32'd0);

        // 6: asynchronous reset mid-lock
        step(to_gray((m_bin + 1) % 16), 1'b1, 1'b0, "pre6");
        step(to_gray((m_bin + 1) % 16), 1'b1, 1'b0, "pre6");
        step(to_gray((m_bin + 7) % 16), 1'b1, 1'b0, "pre6bad");
        step(to_gray((m_bin + 1) % 16), 1'b1, 1'b0, "pre6");
        step(to_gray((m_bin + 1) % 16), 1'b1, 1'b0, "pre6");
        chk("pre6_lk", 32'(bus.locked), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(to_gray(9), 1'b1, 1'b0, "first");
        chk("first_bin", 32'(bus.bin_out), 32'd9);
        step(to_gray(10), 1'b1, 1'b0, "after");
        step(to_gray(11), 1'b1, 1'b0, "after");
        chk("after_lk", 32'(bus.locked), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
